// File: rtl/aes_inv_core.sv
// aes_inv_core: iterative AES-128 inverse cipher, one round per clock.
// Round keys are produced on the fly: forward expansion to RK10, then
// stepped backwards one round key per clock while the rounds run.

// GF(2^8) multiplicative inverse (x^254, 0 maps to 0), reduction poly 0x11b.
module aes_gf_inv (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252;

  assign w_x2   = gf_mul(i_byte, i_byte);
  assign w_x3   = gf_mul(w_x2, i_byte);
  assign w_x6   = gf_mul(w_x3, w_x3);
  assign w_x12  = gf_mul(w_x6, w_x6);
  assign w_x15  = gf_mul(w_x12, w_x3);
  assign w_x30  = gf_mul(w_x15, w_x15);
  assign w_x60  = gf_mul(w_x30, w_x30);
  assign w_x120 = gf_mul(w_x60, w_x60);
  assign w_x240 = gf_mul(w_x120, w_x120);
  assign w_x252 = gf_mul(w_x240, w_x12);
  assign o_byte = gf_mul(w_x252, w_x2);
endmodule

// Forward AES S-box: inverse followed by the affine transform.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  logic [7:0] w_inv;

  aes_gf_inv u_inv (.i_byte(i_byte), .o_byte(w_inv));

  assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]} ^
                  {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

// Inverse AES S-box: inverse affine transform followed by the inverse.
module aes_inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  logic [7:0] w_aff;

  assign w_aff = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]} ^
                 {i_byte[1:0], i_byte[7:2]} ^ 8'h05;

  aes_gf_inv u_inv (.i_byte(w_aff), .o_byte(o_byte));
endmodule

module aes_inv_core (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iStart,
  input  logic [127:0] iCiphertext,
  input  logic [127:0] iKey,
  output logic [127:0] oPlaintext,
  output logic         oDone,
  output logic         oBusy
);
  typedef enum logic [1:0] {IDLE, KEXP, INIT, ROUND} state_t;

  state_t       r_state;
  logic [127:0] r_ct, r_key, r_st;
  logic [7:0]   r_rcon;
  logic [3:0]   r_cnt;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int unsigned i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Key schedule: one set of 4 S-boxes serves both directions. Forward
  // steps feed w3; backward steps feed the recovered previous w3 (w3^w2),
  // and the new w0 expression is identical in both directions.
  logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_prev3, w_sw_in, w_rot, w_sub, w_nw0;
  logic [31:0]  w_f1, w_f2, w_f3;
  logic [127:0] w_key_fwd, w_key_bwd;
  logic [7:0]   w_rcon_bwd;

  assign w_w0    = r_key[127:96];
  assign w_w1    = r_key[95:64];
  assign w_w2    = r_key[63:32];
  assign w_w3    = r_key[31:0];
  assign w_prev3 = w_w3 ^ w_w2;
  assign w_sw_in = (r_state == KEXP) ? w_w3 : w_prev3;
  assign w_rot   = {w_sw_in[23:0], w_sw_in[31:24]};

  genvar j;
  generate
    for (j = 0; j < 4; j++) begin : g_ksbox
      aes_sbox u_sbox (.i_byte(w_rot[31-8*j -: 8]), .o_byte(w_sub[31-8*j -: 8]));
    end
  endgenerate

  assign w_nw0      = w_w0 ^ w_sub ^ {r_rcon, 24'h000000};
  assign w_f1       = w_w1 ^ w_nw0;
  assign w_f2       = w_w2 ^ w_f1;
  assign w_f3       = w_w3 ^ w_f2;
  assign w_key_fwd  = {w_nw0, w_f1, w_f2, w_f3};
  assign w_key_bwd  = {w_nw0, w_w1 ^ w_w0, w_w2 ^ w_w1, w_prev3};
  assign w_rcon_bwd = (r_rcon == 8'h1b) ? 8'h80 : {1'b0, r_rcon[7:1]};

  // Round datapath: InvShiftRows folded into the inverse S-box input wiring.
  logic [127:0] w_isb, w_ark, w_imc;

  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_isbox
      localparam int R   = i % 4;
      localparam int C   = i / 4;
      localparam int SRC = R + 4 * ((C + 4 - R) % 4);
      aes_inv_sbox u_isbox (.i_byte(r_st[127-8*SRC -: 8]), .o_byte(w_isb[127-8*i -: 8]));
    end
  endgenerate

  assign w_ark = w_isb ^ r_key;

  generate
    for (i = 0; i < 4; i++) begin : g_imc
      assign w_imc[127-32*i -: 32] = inv_mix_col(w_ark[127-32*i -: 32]);
    end
  endgenerate

  // Control FSM with registered outputs; key and state advance one step per edge.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= IDLE;
      r_ct       <= '0;
      r_key      <= '0;
      r_st       <= '0;
      r_rcon     <= '0;
      r_cnt      <= '0;
      oPlaintext <= '0;
      oDone      <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          oDone <= 1'b0;
          oBusy <= 1'b0;
          if (iStart) begin
            r_ct    <= iCiphertext;
            r_key   <= iKey;
            r_rcon  <= 8'h01;
            r_cnt   <= '0;
            r_state <= KEXP;
          end
        end
        KEXP: begin
          oBusy <= 1'b1;
          r_key <= w_key_fwd;
          if (r_cnt == 4'd9) begin
            r_state <= INIT;
          end else begin
            r_rcon <= xtime(r_rcon);
            r_cnt  <= r_cnt + 4'd1;
          end
        end
        INIT: begin
          r_st    <= r_ct ^ r_key;
          r_key   <= w_key_bwd;
          r_rcon  <= w_rcon_bwd;
          r_cnt   <= 4'd9;
          r_state <= ROUND;
        end
        ROUND: begin
          r_key  <= w_key_bwd;
          r_rcon <= w_rcon_bwd;
          if (r_cnt == 4'd0) begin
            r_st       <= w_ark;
            oPlaintext <= w_ark;
            oDone      <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_st  <= w_imc;
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_core.sv
// Testbench for aes_inv_core: known-answer vectors, control corner cases,
// and random loopback against a table-based AES-128 encryption model.
module tb_aes_inv_core;
  logic         iClk = 1'b0;
  logic         iRst, iStart;
  logic [127:0] iCiphertext, iKey, oPlaintext;
  logic         oDone, oBusy;

  always #5 iClk = ~iClk;

  aes_inv_core dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iCiphertext(iCiphertext),
    .iKey(iKey), .oPlaintext(oPlaintext), .oDone(oDone), .oBusy(oBusy)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] sb [256];
  logic [7:0] ex [256];
  logic [7:0] lg [256];

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  vec_t vt [3];

  localparam logic [127:0] T1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] T1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] T1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] T2K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] T2C = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] T2P = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return ex[(int'(lg[a]) + int'(lg[b])) % 255];
  endfunction

  // Log/antilog tables over generator 3, then S-box = affine(inverse).
  function automatic void build_tables();
    logic [7:0] p, inv, s;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = 8'(i);
      p = p ^ ({p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00));
    end
    ex[255] = ex[0];
    lg[0]   = 8'h00;
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - int'(lg[x])) % 255];
      for (int k = 0; k < 8; k++)
        s[k] = inv[k] ^ inv[(k+4)%8] ^ inv[(k+5)%8] ^ inv[(k+6)%8] ^ inv[(k+7)%8];
      sb[x] = s ^ 8'h63;
    end
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = gm(8'h02, a0) ^ gm(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(8'h02, a1) ^ gm(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(8'h02, a2) ^ gm(8'h03, a3);
          s[4*c+3] = gm(8'h03, a0) ^ a1 ^ a2 ^ gm(8'h02, a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // One decryption: start, optional busy-time start pulse (inj) or reset (rstc)
  // before the given cycle, then observe 30 cycles after the start edge.
  task automatic op(input logic [127:0] k, input logic [127:0] c, input int inj, input int rstc,
                    output int dc, output int nd, output logic bok, output logic rz,
                    output logic [127:0] ptd);
    int lim;
    lim = (rstc != 0) ? rstc - 1 : 21;
    iKey = k; iCiphertext = c; iStart = 1'b1;
    tick;
    iStart = 1'b0; iKey = ~k; iCiphertext = ~c;
    dc = 0; nd = 0; bok = 1'b1; rz = 1'b0; ptd = '0;
    for (int cy = 1; cy <= 30; cy++) begin
      if (cy == inj) begin iStart = 1'b1; iKey = T2K; iCiphertext = T2C; end
      if (cy == rstc) iRst = 1'b1;
      tick;
      iStart = 1'b0; iRst = 1'b0;
      if (oDone) begin
        nd++;
        if (dc == 0) begin dc = cy; ptd = oPlaintext; end
      end
      if (oBusy !== (cy <= lim)) bok = 1'b0;
      if (cy == rstc) rz = (oPlaintext == '0) && !oDone && !oBusy;
    end
  endtask

  initial begin
    int dc, nd;
    logic bok, rz;
    logic [127:0] ptd, rk, rp, rc;

    iRst = 1'b1; iStart = 1'b0; iKey = '0; iCiphertext = '0;
    build_tables();
    vt[0] = '{key: T1K, ct: T1C, pt: T1P};
    vt[1] = '{key: T2K, ct: T2C, pt: T2P};
    vt[2] = '{key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, pt: 128'h0};

    tick; tick;
    check("rst_pt", oPlaintext, '0);
    check("rst_done", 128'(oDone), 0);
    check("rst_busy", 128'(oBusy), 0);
    iRst = 1'b0;
    tick;

    for (int v = 0; v < 3; v++) begin
      op(vt[v].key, vt[v].ct, 0, 0, dc, nd, bok, rz, ptd);
      check($sformatf("vec%0d_pt", v), ptd, vt[v].pt);
      check($sformatf("vec%0d_lat", v), 128'(dc), 21);
      check($sformatf("vec%0d_ndone", v), 128'(nd), 1);
      check($sformatf("vec%0d_busy", v), 128'(bok), 1);
      check($sformatf("vec%0d_hold", v), oPlaintext, vt[v].pt);
    end

    // Start pulse while busy must be ignored.
    op(T1K, T1C, 5, 0, dc, nd, bok, rz, ptd);
    check("busystart_pt", ptd, T1P);
    check("busystart_ndone", 128'(nd), 1);
    check("busystart_busy", 128'(bok), 1);

    // Reset mid-operation aborts, then a fresh run works.
    op(T1K, T1C, 0, 12, dc, nd, bok, rz, ptd);
    check("midrst_ndone", 128'(nd), 0);
    check("midrst_zero", 128'(rz), 1);
    check("midrst_busy", 128'(bok), 1);
    op(T2K, T2C, 0, 0, dc, nd, bok, rz, ptd);
    check("postrst_pt", ptd, T2P);
    check("postrst_lat", 128'(dc), 21);

    // Back-to-back: iStart held high through the first oDone cycle.
    iKey = T1K; iCiphertext = T1C; iStart = 1'b1;
    tick;
    dc = 0;
    for (int cy = 1; cy <= 30; cy++) begin
      tick;
      if (oDone) begin dc = cy; break; end
    end
    check("b2b_lat1", 128'(dc), 21);
    check("b2b_pt1", oPlaintext, T1P);
    iKey = T2K; iCiphertext = T2C;
    tick;
    iStart = 1'b0;
    dc = 0;
    for (int cy = 1; cy <= 30; cy++) begin
      tick;
      if (oDone) begin dc = cy; break; end
    end
    check("b2b_lat2", 128'(dc), 21);
    check("b2b_pt2", oPlaintext, T2P);
    tick;

    // Random loopback through the encryption model.
    for (int n = 0; n < 1000; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      rc = aes_enc(rk, rp);
      op(rk, rc, 0, 0, dc, nd, bok, rz, ptd);
      check($sformatf("loop%0d_pt", n), ptd, rp);
      check($sformatf("loop%0d_lat", n), 128'(dc), 21);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
